// File: rtl/gpu_pkg.sv
// Shared constants for the page-flipping GPU front end: register map,
// control/status field positions and engine states.
package gpu_pkg;
    localparam logic [10:0] CTRL_OFF_DEF   = 11'd0;
    localparam logic [10:0] STATUS_OFF_DEF = 11'd2;
    localparam logic [10:0] CHAR_BASE_DEF  = 11'd4;
    localparam logic [63:0] CTRL_RESET     = 64'h2;

    localparam int CTRL_COPY      = 0;
    localparam int CTRL_CLEAR     = 1;
    localparam int CTRL_MODE_LSB  = 2;
    localparam int CTRL_MODE_W    = 13;
    localparam int CTRL_WPAGE_LSB = 16;
    localparam int CTRL_SPAGE_LSB = 24;

    localparam int ST_VBLANK  = 0;
    localparam int ST_BUSY    = 1;
    localparam int ST_PENDING = 2;
    localparam int ST_ERROR   = 3;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_PAUSE, S_DONE} state_e;
endpackage

// File: rtl/gpu_page_ram.sv
// Simple dual-port page RAM: one write port, one registered read port.
// A read colliding with a write to the same address returns the old word.
module gpu_page_ram #(
    parameter int DEPTH = 1200,
    parameter int W     = 64
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/gpu_page_flipper.sv
// Multi-page text/pixel frame store: bus-writable back pages, a display-scanned
// front buffer and a vblank-gated engine that copies or clears into it.
module gpu_page_flipper
    import gpu_pkg::*;
#(
    parameter logic [7:0]  DEVICE_ID  = 8'h02,
    parameter int          COLS       = 40,
    parameter int          ROWS       = 30,
    parameter int          CHARS      = COLS*ROWS,
    parameter int          PAGES      = 2,
    parameter logic [10:0] CTRL_OFF   = CTRL_OFF_DEF,
    parameter logic [10:0] STATUS_OFF = STATUS_OFF_DEF,
    parameter logic [10:0] CHAR_BASE  = CHAR_BASE_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [63:0]              address,
    input  logic [63:0]              write_data,
    input  logic                     read,
    input  logic                     write,
    output logic [63:0]              read_data,
    output logic                     read_valid,
    input  logic                     vblank,
    input  logic [$clog2(CHARS)-1:0] display_address,
    output logic [63:0]              display_data,
    output logic [12:0]              mode_bits,
    output logic                     busy
);
    localparam int AW = $clog2(CHARS);
    localparam int CW = $clog2(CHARS+1);
    localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam logic [10:0] CHAR_END = 11'(CHAR_BASE + CHARS);

    state_e        state_q, state_d;
    logic [63:0]   control_q, control_d;
    logic          error_q, error_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inflight_q, inflight_d;
    logic          op_clear_q, op_clear_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          rchar_q, rchar_d;
    logic [PW-1:0] rpage_q, rpage_d;

    logic [PAGES-1:0]        back_we;
    logic [AW-1:0]           back_waddr, back_raddr, front_waddr;
    logic [63:0]             back_wdata, front_wdata;
    logic [PAGES-1:0][63:0]  back_rd;
    logic                    front_we;
    logic [63:0]             status;

    wire [10:0]   off      = address[10:0];
    wire          hit      = address[63:56] == DEVICE_ID;
    wire          is_ctrl  = off == CTRL_OFF;
    wire          is_stat  = off == STATUS_OFF;
    wire          is_char  = (off >= CHAR_BASE) && (off < CHAR_END);
    wire [10:0]   char_off = off - CHAR_BASE;
    wire [AW-1:0] char_idx = AW'(char_off);
    wire [PW-1:0] wpage    = control_q[CTRL_WPAGE_LSB +: PW];
    wire [PW-1:0] spage    = control_q[CTRL_SPAGE_LSB +: PW];
    wire          pending  = |control_q[CTRL_CLEAR:CTRL_COPY];
    wire          unused_addr = ^address[55:11];

    assign busy       = state_q != S_IDLE;
    assign mode_bits  = control_q[CTRL_MODE_LSB +: CTRL_MODE_W];
    assign read_valid = rvalid_q;
    assign read_data  = rchar_q ? back_rd[rpage_q] : rdata_q;

    always_comb begin
        status             = '0;
        status[ST_VBLANK]  = vblank;
        status[ST_BUSY]    = busy;
        status[ST_PENDING] = pending;
        status[ST_ERROR]   = error_q;
    end

    always_comb begin
        state_d     = state_q;
        control_d   = control_q;
        error_d     = error_q;
        cnt_d       = cnt_q;
        inflight_d  = inflight_q;
        op_clear_d  = op_clear_q;
        rvalid_d    = 1'b0;
        rchar_d     = 1'b0;
        rpage_d     = rpage_q;
        // a char read's RAM word is captured so read_data holds afterwards
        rdata_d     = rchar_q ? back_rd[rpage_q] : rdata_q;
        back_we     = '0;
        back_waddr  = char_idx;
        back_wdata  = write_data;
        back_raddr  = char_idx;
        front_we    = 1'b0;
        front_waddr = AW'(cnt_q);
        front_wdata = '0;

        if (write && hit) begin
            if (is_ctrl) begin
                if (busy) error_d = 1'b1;
                else      control_d = write_data;
            end else if (is_stat) begin
                error_d = 1'b0;
            end else if (is_char) begin
                if (busy) error_d = 1'b1;
                else      back_we[wpage] = 1'b1;
            end
        end else if (read && !write) begin
            rdata_d = '0;
            if (hit) begin
                if (is_ctrl) begin
                    rvalid_d = 1'b1;
                    rdata_d  = control_q;
                end else if (is_stat) begin
                    rvalid_d = 1'b1;
                    rdata_d  = status;
                end else if (is_char) begin
                    rvalid_d = 1'b1;
                    if (busy) error_d = 1'b1;
                    else begin
                        rchar_d = 1'b1;
                        rpage_d = wpage;
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: if (pending) state_d = S_WAIT;
            S_WAIT: if (vblank) begin
                state_d    = S_RUN;
                op_clear_d = control_q[CTRL_CLEAR];
                cnt_d      = '0;
                inflight_d = 1'b0;
            end
            S_RUN: begin
                if (!vblank) begin
                    // drop the in-flight word and rewind so resume reissues it
                    state_d    = S_PAUSE;
                    inflight_d = 1'b0;
                    if (inflight_q) cnt_d = cnt_q - 1'b1;
                end else if (op_clear_q) begin
                    back_we     = '1;
                    back_waddr  = AW'(cnt_q);
                    back_wdata  = '0;
                    front_we    = 1'b1;
                    if (cnt_q == CW'(CHARS-1)) state_d = S_DONE;
                    else                       cnt_d = cnt_q + 1'b1;
                end else begin
                    inflight_d = cnt_q < CW'(CHARS);
                    if (cnt_q < CW'(CHARS)) back_raddr = AW'(cnt_q);
                    if (inflight_q) begin
                        front_we    = 1'b1;
                        front_waddr = AW'(cnt_q - 1'b1);
                        front_wdata = back_rd[spage];
                    end
                    if (cnt_q == CW'(CHARS)) state_d = S_DONE;
                    else                     cnt_d = cnt_q + 1'b1;
                end
            end
            S_PAUSE: if (vblank) state_d = S_RUN;
            S_DONE: begin
                control_d[op_clear_q ? CTRL_CLEAR : CTRL_COPY] = 1'b0;
                if (op_clear_q ? control_q[CTRL_COPY] : control_q[CTRL_CLEAR]) state_d = S_WAIT;
                else                                                            state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            control_q  <= CTRL_RESET;
            error_q    <= 1'b0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            op_clear_q <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rchar_q    <= 1'b0;
            rpage_q    <= '0;
        end else begin
            state_q    <= state_d;
            control_q  <= control_d;
            error_q    <= error_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            op_clear_q <= op_clear_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            rchar_q    <= rchar_d;
            rpage_q    <= rpage_d;
        end
    end

    gpu_page_ram #(.DEPTH(CHARS), .W(64)) u_front (
        .clock (clock),
        .we    (front_we),
        .waddr (front_waddr),
        .wdata (front_wdata),
        .raddr (display_address),
        .rdata (display_data)
    );

    for (genvar p = 0; p < PAGES; p++) begin : g_back
        gpu_page_ram #(.DEPTH(CHARS), .W(64)) u_back (
            .clock (clock),
            .we    (back_we[p]),
            .waddr (back_waddr),
            .wdata (back_wdata),
            .raddr (back_raddr),
            .rdata (back_rd[p])
        );
    end
endmodule

// File: tb/tb_gpu_page_flipper.sv
// Bench for gpu_page_flipper: bus vector table, hand-written engine sequences and
// randomized copies, all checked against a page-level buffer model.
module tb_gpu_page_flipper;
    localparam int CHARS = 1200;
    localparam int PAGES = 2;
    localparam int AW    = 11;

    logic          clock = 1'b0, reset = 1'b1, read = 1'b0, write = 1'b0, vblank = 1'b0;
    logic [63:0]   address = '0, write_data = '0;
    logic [63:0]   read_data, display_data;
    logic          read_valid, busy;
    logic [AW-1:0] display_address = '0;
    logic [12:0]   mode_bits;

    int n_vec = 0, n_err = 0;
    logic [63:0] front_m [CHARS];
    logic [63:0] back_m  [PAGES][CHARS];
    logic [63:0] ctrl_m;

    gpu_page_flipper dut (
        .clock(clock), .reset(reset), .address(address), .write_data(write_data),
        .read(read), .write(write), .read_data(read_data), .read_valid(read_valid),
        .vblank(vblank), .display_address(display_address), .display_data(display_data),
        .mode_bits(mode_bits), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  dev;
        logic [10:0] off;
        logic [63:0] wd;
        logic        ev;
        logic [63:0] ed;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] ad(input logic [7:0] dev, input logic [10:0] off);
        return {dev, 45'd0, off};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic bwr(input logic [7:0] dev, input logic [10:0] off, input logic [63:0] d);
        address = ad(dev, off); write_data = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic brd(input logic [7:0] dev, input logic [10:0] off,
                       output logic [63:0] d, output logic v);
        address = ad(dev, off); read = 1'b1;
        tick();
        read = 1'b0;
        d = read_data; v = read_valid;
    endtask

    task automatic set_ctrl(input logic [63:0] v);
        bwr(8'h02, 11'd0, v);
        ctrl_m = v;
    endtask

    task automatic chk_ctrl(input string nm);
        logic [63:0] d; logic v;
        brd(8'h02, 11'd0, d, v);
        chk({nm, " valid"}, 64'(v), 64'd1);
        chk(nm, d, ctrl_m);
    endtask

    task automatic run_engine(input string nm, input int budget, input bit rand_vb, output int cyc);
        cyc = 0;
        do begin
            if (rand_vb) vblank = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end while (busy && cyc < budget);
        if (busy) begin
            n_vec++; n_err++;
            $display("FAIL %s: engine still busy after %0d cycles", nm, cyc);
        end
        vblank = 1'b1;
    endtask

    task automatic model_clear();
        for (int a = 0; a < CHARS; a++) begin
            front_m[a] = '0;
            for (int p = 0; p < PAGES; p++) back_m[p][a] = '0;
        end
        ctrl_m[1] = 1'b0;
    endtask

    task automatic model_copy(input int p);
        for (int a = 0; a < CHARS; a++) front_m[a] = back_m[p][a];
        ctrl_m[0] = 1'b0;
    endtask

    task automatic verify_front(input string nm);
        for (int a = 0; a < CHARS; a++) begin
            display_address = AW'(a);
            tick();
            chk($sformatf("%s front[%0d]", nm, a), display_data, front_m[a]);
        end
    endtask

    task automatic verify_back(input string nm, input int p);
        logic [63:0] d; logic v;
        set_ctrl(64'(p) << 16);
        for (int a = 0; a < CHARS; a++) begin
            brd(8'h02, 11'(4 + a), d, v);
            chk($sformatf("%s back%0d[%0d]", nm, p, a), d, back_m[p][a]);
        end
    endtask

    task automatic random_fill(input int p);
        logic [63:0] w;
        set_ctrl(64'(p) << 16);
        for (int a = 0; a < CHARS; a++) begin
            w = {$urandom, $urandom};
            bwr(8'h02, 11'(4 + a), w);
            back_m[p][a] = w;
        end
    endtask

    initial begin
        vec_t        tbl [14];
        logic [63:0] d;
        logic        v;
        int          cyc, p;

        tbl[0]  = '{0, 1, 8'h02, 11'd4,    64'hA5A5, 0, 64'h0};
        tbl[1]  = '{0, 1, 8'h02, 11'd1203, 64'hBEEF, 0, 64'h0};
        tbl[2]  = '{1, 0, 8'h02, 11'd4,    64'h0,    1, 64'hA5A5};
        tbl[3]  = '{1, 0, 8'h02, 11'd1203, 64'h0,    1, 64'hBEEF};
        tbl[4]  = '{1, 0, 8'h03, 11'd2,    64'h0,    0, 64'h0};
        tbl[5]  = '{1, 0, 8'h02, 11'd2,    64'h0,    1, 64'h0};
        tbl[6]  = '{1, 0, 8'h02, 11'd1,    64'h0,    0, 64'h0};
        tbl[7]  = '{1, 0, 8'h02, 11'd1204, 64'h0,    0, 64'h0};
        tbl[8]  = '{1, 0, 8'h02, 11'd4,    64'h0,    1, 64'hA5A5};
        tbl[9]  = '{1, 1, 8'h02, 11'd5,    64'h77,   0, 64'hA5A5};
        tbl[10] = '{1, 0, 8'h02, 11'd5,    64'h0,    1, 64'h77};
        tbl[11] = '{0, 1, 8'h02, 11'd3,    64'h99,   0, 64'h0};
        tbl[12] = '{1, 0, 8'h02, 11'd3,    64'h0,    0, 64'h0};
        tbl[13] = '{1, 0, 8'h02, 11'd0,    64'h0,    1, 64'h0};

        // reset state, then the reset-requested clear held off by vblank
        reset = 1'b1; vblank = 1'b0;
        tick(); tick();
        chk("reset read_valid", 64'(read_valid), 64'd0);
        chk("reset read_data", read_data, 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset mode_bits", 64'(mode_bits), 64'd0);
        reset = 1'b0; ctrl_m = 64'h2;
        repeat (100) tick();
        chk("wait busy", 64'(busy), 64'd1);
        brd(8'h02, 11'd2, d, v);
        chk("wait status", d, 64'h6);
        chk_ctrl("wait ctrl");
        vblank = 1'b1;
        run_engine("reset clear", 5000, 1'b0, cyc);
        chk("clear cycles", 64'(cyc), 64'(CHARS + 2));
        model_clear();
        chk_ctrl("ctrl after clear");
        verify_front("clear");
        verify_back("clear", 0);
        verify_back("clear", 1);

        // bus vector table on page 0, idle engine
        set_ctrl(64'h0);
        vblank = 1'b0;
        for (int i = 0; i < 14; i++) begin
            address = ad(tbl[i].dev, tbl[i].off); write_data = tbl[i].wd;
            read = tbl[i].rd; write = tbl[i].wr;
            tick();
            read = 1'b0; write = 1'b0;
            if (tbl[i].wr && tbl[i].dev == 8'h02 && tbl[i].off >= 11'd4 && tbl[i].off < 11'd1204)
                back_m[0][tbl[i].off - 11'd4] = tbl[i].wd;
            if (tbl[i].rd) begin
                chk($sformatf("tbl%0d valid", i), 64'(read_valid), 64'(tbl[i].ev));
                chk($sformatf("tbl%0d data", i), read_data, tbl[i].ed);
            end
        end

        // mode passthrough and readback of otherwise unused control bits
        set_ctrl(64'hF0F0_0000_0000_5554);
        chk("mode_bits", 64'(mode_bits), 64'h1555);
        chk_ctrl("ctrl readback");

        // copy page 1 to the front buffer
        set_ctrl(64'h1_0000);
        bwr(8'h02, 11'd4, 64'hDEAD);
        back_m[1][0] = 64'hDEAD;
        set_ctrl(64'h0100_0000 | 64'h1_0000 | 64'h1);
        vblank = 1'b0;
        repeat (5) tick();
        chk("copy waits", 64'(busy), 64'd1);
        vblank = 1'b1;
        run_engine("copy p1", 5000, 1'b0, cyc);
        chk("copy cycles", 64'(cyc), 64'(CHARS + 3));
        model_copy(1);
        chk_ctrl("ctrl after copy");
        display_address = '0;
        tick();
        chk("front[0] DEAD", display_data, 64'hDEAD);
        verify_back("page0 kept", 0);

        // pause at c=500 for 50 cycles
        random_fill(0);
        set_ctrl(64'h1);
        vblank = 1'b1;
        repeat (502) tick();
        vblank = 1'b0;
        repeat (50) tick();
        chk("busy in pause", 64'(busy), 64'd1);
        brd(8'h02, 11'd2, d, v);
        chk("status in pause", d, 64'h6);
        vblank = 1'b1;
        run_engine("paused copy", 5000, 1'b0, cyc);
        model_copy(0);
        verify_front("paused copy");

        // bus accesses while busy
        back_m[0][0] = 64'h1234_5678;
        bwr(8'h02, 11'd4, back_m[0][0]);
        set_ctrl(64'h1);
        vblank = 1'b0;
        repeat (3) tick();
        bwr(8'h02, 11'd4, 64'h1);
        brd(8'h02, 11'd2, d, v);
        chk("err after char write", d, 64'hE);
        bwr(8'h02, 11'd2, 64'h0);
        brd(8'h02, 11'd2, d, v);
        chk("err cleared", d, 64'h6);
        brd(8'h02, 11'd4, d, v);
        chk("busy char read valid", 64'(v), 64'd1);
        chk("busy char read data", d, 64'h0);
        brd(8'h02, 11'd2, d, v);
        chk("err after char read", d, 64'hE);
        bwr(8'h02, 11'd2, 64'h0);
        bwr(8'h02, 11'd0, 64'h2);
        brd(8'h02, 11'd2, d, v);
        chk("err after ctrl write", d, 64'hE);
        bwr(8'h02, 11'd2, 64'h0);
        chk_ctrl("ctrl write dropped");
        vblank = 1'b1;
        run_engine("busy copy", 5000, 1'b0, cyc);
        model_copy(0);
        chk_ctrl("ctrl after busy copy");
        brd(8'h02, 11'd4, d, v);
        chk("word kept", d, back_m[0][0]);
        verify_front("busy copy");

        // clear and copy requested together
        set_ctrl(64'h3);
        run_engine("clear+copy", 8000, 1'b0, cyc);
        chk("clear+copy cycles", 64'(cyc), 64'(2 * CHARS + 6));
        model_clear();
        model_copy(0);
        chk_ctrl("ctrl after clear+copy");
        verify_front("clear+copy");

        // randomized copies with vblank toggling
        for (int t = 0; t < 3; t++) begin
            p = int'($urandom_range(0, PAGES - 1));
            random_fill(p);
            set_ctrl((64'(p) << 24) | 64'h1);
            run_engine("random copy", 30000, 1'b1, cyc);
            model_copy(p);
            chk_ctrl("ctrl after random copy");
            verify_front($sformatf("rand%0d", t));
        end

        // reset in the middle of a copy
        set_ctrl(64'h1);
        repeat (300) tick();
        reset = 1'b1;
        tick();
        chk("mid reset busy", 64'(busy), 64'd0);
        chk("mid reset read_valid", 64'(read_valid), 64'd0);
        reset = 1'b0;
        ctrl_m = 64'h2;
        chk_ctrl("ctrl after mid reset");
        run_engine("repair clear", 5000, 1'b0, cyc);
        model_clear();
        chk_ctrl("ctrl after repair");
        verify_front("repair");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gpu_page_flipper.md
Name: gpu_page_flipper

Overview:
- Parametrised successor to the single-page text-mode GPU front end.
- Holds PAGES back buffers of CHARS 64-bit character/pixel words, writable from the processor bus, plus one front buffer scanned by the display path.
- A vblank-gated copy/clear engine moves the selected back page into the front buffer.
- Sits between the processor bus decode and the char/pixel display unit, in the processor clock domain; vblank arrives already synchronised.

Parameters:
- DEVICE_ID, 8'h02, value of address[63:56] that selects this block.
- COLS, 40, text columns.
- ROWS, 30, text rows.
- CHARS, COLS*ROWS, words per page (1200).
- PAGES, 2, number of back pages (power of two, at least 1).
- CTRL_OFF, 11'd0, control register offset.
- STATUS_OFF, 11'd2, status register offset.
- CHAR_BASE, 11'd4, first character offset; the character window is [CHAR_BASE, CHAR_BASE+CHARS).

Ports:
- clock, in, 1, processor clock; all state updates on posedge.
- reset, in, 1, synchronous, active-high.
- address, in, 64, bus address.
- write_data, in, 64, bus write data.
- read, in, 1, bus read strobe.
- write, in, 1, bus write strobe.
- read_data, out, 64, registered read data.
- read_valid, out, 1, high for exactly the cycle after an accepted read.
- vblank, in, 1, high during vertical blanking (synchronised).
- display_address, in, clog2(CHARS), front-buffer read address.
- display_data, out, 64, front-buffer word, one cycle after display_address.
- mode_bits, out, 13, control[14:2] passthrough: bit 0 selects pixel mode, bits 12:1 are colour.
- busy, out, 1, engine not IDLE.

Behaviour:
- Decode: hit when address[63:56]==DEVICE_ID. Offset is address[10:0].
- Control register fields:
  - bit0: copy request.
  - bit1: clear request.
  - bits14:2: mode.
  - bits[16+PW-1:16]: write page (bus window target), PW=max(1,clog2(PAGES)).
  - bits[24+PW-1:24]: show page (copy source).
  - all other bits are stored and read back unchanged.
- Status register: {60'b0, error, pending, busy, vblank}.
  - pending = control[1:0]!=0.
  - error is sticky; any write to STATUS clears it.
- Reset values: control=64'h2 (clear pending, write/show page 0), error=0, FSM=IDLE, read_data=0, read_valid=0, counter=0. Buffer contents are undefined until the first clear.
- Bus reads: read_data and read_valid update the cycle after read&hit.
  - A miss, or a read with an offset outside all windows, returns 0 and leaves read_valid low.
  - Character reads return the write page word at offset-CHAR_BASE.
  - read and write in the same cycle: the write wins and no read is performed.
- Bus writes to characters go to the write page.
- While busy:
  - character writes are dropped and set error.
  - control writes are dropped and set error.
  - status and control reads are still served.
  - character reads return 0 and set error.
- FSM states:
  - IDLE: go to WAIT when pending and not busy.
  - WAIT: go to RUN on the first clock with vblank=1. Clear has priority over copy when both are pending.
  - RUN: counter c runs 0..CHARS-1.
    - Copy: issues a back-page read at c and writes the front buffer at c-1 (1-cycle RAM latency), plus a final flush cycle. Total CHARS+1 RUN cycles.
    - Clear: writes 0 to the front buffer and to every back page at c. Total CHARS cycles.
  - PAUSE: entered if vblank falls mid-RUN. The counter holds and the in-flight read is discarded, then reissued on resume. Returns to RUN when vblank rises again.
  - DONE: one cycle. Clears the serviced request bit. If the other request bit is still set, go to WAIT; otherwise go to IDLE.
- reset mid-operation: abort immediately into the reset values above, leaving a partially written front buffer. The clear that reset requests then repairs it.
- The display read port is independent of the engine and always served. Reading an address the engine writes in the same cycle returns the old word.
- The counter never wraps; it stops at CHARS-1 (or CHARS for the copy flush).

Decomposition:
- Package gpu_pkg: offset constants, control field bit positions, status bit positions, FSM state enum.
- One sub-module gpu_page_ram: simple dual-port RAM, one write and one registered read port, with a DEPTH parameter. Instantiate it once for the front buffer and once per back page via generate.

Test Plan:
- Reset, hold vblank=0 for 100 cycles -> busy=1, FSM in WAIT. Raise vblank -> after 1200 RUN cycles plus DONE, every front and back word is 0 and control reads 64'h0.
- Write page 1 word at offset 4 = 64'hDEAD. Set show page 1 and copy. Pulse vblank -> display_address=0 gives 64'hDEAD; page 0 is unchanged.
- Drop vblank at c=500 during a copy, raise it 50 cycles later -> copy completes. All 1200 front words match the source and status.busy falls only after completion.
- Character write of 64'h1 while busy -> the word is unchanged and status bit3=1. Write STATUS -> bit3=0.
- Set control bits1:0=2'b11 -> clear runs first, then copy of a zero page. Two DONE cycles occur; control[1:0]=0.
- Read at offset 2 with DEVICE_ID 8'h03 -> read_valid=0 and read_data=0. With DEVICE_ID 8'h02 -> read_valid=1 on the next cycle.
